regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 74 +++++++
 tb/tb_regfile_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised register file: two async read ports, one write port, and a background soft clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_param #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    add1,
  input  logic [AW-1:0]    add2,
  input  logic [AW-1:0]    addw,
  input  logic             write,
  input  logic [WIDTH-1:0] wd,
  input  logic             clr,
  output logic [WIDTH-1:0] ar,
  output logic [WIDTH-1:0] br,
  output logic             wr_ready,
  output logic             busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             wr_zero;

  // Entry 0 is hard-wired when ZERO_REG is set, so writes to it never land or forward.
  assign wr_zero  = (ZERO_REG != 0) && (addw == '0);
  assign wr_en    = write && (state == IDLE) && !wr_zero;
  assign wr_ready = (state == IDLE);
  assign busy     = (state == CLEAR);

  // State, clear pointer and storage; a clear walks one entry per cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) mem[addw] <= wd;
          if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          mem[ptr] <= '0;
          ptr      <= ptr + AW'(1);
          if (ptr == AW'(DEPTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Asynchronous read ports.
  always_comb begin
    ar = mem[add1];
    br = mem[add2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (addw == add1)) ar = wd;
    if (wr_en && (addw == add2)) br = wd;
`endif
    if ((ZERO_REG != 0) && (add1 == '0)) ar = '0;
    if ((ZERO_REG != 0) && (add2 == '0)) br = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a reference model feeds an expected-value queue checked each sample.
module tb_regfile_param;

  logic        clock;
  logic        reset;
  logic [2:0]  add1, add2, addw;
  logic        write, clr;
  logic [15:0] wd;
  logic [15:0] ar, br, zar, zbr;
  logic        wr_ready, busy, zwr_ready, zbusy;

  int checks = 0;
  int errors = 0;

  logic [15:0] m0 [8];
  logic [15:0] mz [8];
  logic        m_busy;
  int          m_ptr;
  logic [15:0] exp_q [$];

  regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut (
    .clock(clock), .reset(reset), .add1(add1), .add2(add2), .addw(addw),
    .write(write), .wd(wd), .clr(clr), .ar(ar), .br(br),
    .wr_ready(wr_ready), .busy(busy)
  );

  regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1)) dut_z (
    .clock(clock), .reset(reset), .add1(add1), .add2(add2), .addw(addw),
    .write(write), .wd(wd), .clr(clr), .ar(zar), .br(zbr),
    .wr_ready(zwr_ready), .busy(zbusy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] exp_rd(input bit zr, input logic [2:0] a);
    logic [15:0] v;
    v = zr ? mz[a] : m0[a];
`ifdef REGFILE_BYPASS_EN
    if (write && !m_busy && (addw == a)) v = wd;
`endif
    if (zr && (a == 3'd0)) v = 16'h0000;
    return v;
  endfunction

  // Reference behaviour for one rising edge given the inputs currently driven.
  task automatic model_step();
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin m0[i] = '0; mz[i] = '0; end
      m_busy = 1'b0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      if (write) begin
        m0[addw] = wd;
        if (addw != 3'd0) mz[addw] = wd;
      end
      if (clr) begin m_busy = 1'b1; m_ptr = 0; end
    end else begin
      m0[m_ptr] = '0;
      mz[m_ptr] = '0;
      if (m_ptr == 7) m_busy = 1'b0;
      m_ptr = (m_ptr + 1) % 8;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  // Queue expectations for the inputs now driven, then compare the DUT outputs against them.
  task automatic observe(input string tag);
    logic [15:0] obs [6];
    string       nm  [6];
    logic [15:0] e;
    exp_q.push_back(exp_rd(1'b0, add1));
    exp_q.push_back(exp_rd(1'b0, add2));
    exp_q.push_back(exp_rd(1'b1, add1));
    exp_q.push_back(exp_rd(1'b1, add2));
    exp_q.push_back({15'd0, !m_busy});
    exp_q.push_back({15'd0, m_busy});
    #1;
    obs[0] = ar;  obs[1] = br;  obs[2] = zar;  obs[3] = zbr;
    obs[4] = {15'd0, wr_ready}; obs[5] = {15'd0, busy};
    nm[0] = "ar"; nm[1] = "br"; nm[2] = "zar"; nm[3] = "zbr";
    nm[4] = "wr_ready"; nm[5] = "busy";
    for (int k = 0; k < 6; k++) begin
      e = exp_q.pop_front();
      checks++;
      assert (obs[k] === e) else begin
        errors++;
        $error("FAIL %s.%s observed=%h expected=%h", tag, nm[k], obs[k], e);
      end
    end
    checks++;
    assert ((zwr_ready === wr_ready) && (zbusy === busy)) else begin
      errors++;
      $error("FAIL %s.zflags observed=%b%b expected=%b%b", tag, zwr_ready, zbusy, wr_ready, busy);
    end
  endtask

  task automatic sweep(input string tag);
    write = 1'b0; clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      add1 = 3'(i);
      add2 = 3'(7 - i);
      observe(tag);
      tick();
    end
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 8; i++) begin m0[i] = '0; mz[i] = '0; end
    m_busy = 1'b0; m_ptr = 0;
    reset = 1'b0; write = 1'b0; clr = 1'b0;
    add1 = '0; add2 = 3'd1; addw = '0; wd = '0;
    tick();
    tick();
    reset = 1'b1;
    observe("reset");

    // Single write then full readback.
    write = 1'b1; addw = 3'd3; wd = 16'hBEEF; add1 = 3'd3; add2 = 3'd0;
    observe("wr3_same");
    tick();
    sweep("wr3_read");

    // Same-cycle read of the address being written.
    write = 1'b1; addw = 3'd5; wd = 16'h1234; add1 = 3'd3; add2 = 3'd5;
    observe("bypass5_same");
    tick();
    write = 1'b0;
    observe("bypass5_next");

    // Fill every entry, including entry 0 which the ZERO_REG instance discards.
    for (int i = 0; i < 8; i++) begin
      write = 1'b1; addw = 3'(i); wd = 16'h1000 + 16'(i * 16'h0111);
      add1 = 3'(i); add2 = 3'd0;
      observe("fill");
      tick();
    end
    sweep("fill_read");

    // Pulse clear, then retrigger clr and attempt a write while clearing.
    write = 1'b0; clr = 1'b1; add1 = 3'd0; add2 = 3'd7;
    observe("clr_pulse");
    tick();
    clr = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      clr   = (i == 3);
      write = (i == 5);
      addw  = 3'd2;
      wd    = 16'hAAAA;
      add1  = (i == 4) ? 3'd3 : 3'(i % 8);
      add2  = (i == 4) ? 3'd4 : 3'((i + 7) % 8);
      observe("clearing");
      tick();
      cnt++;
    end
    checks++;
    assert (cnt === 8) else begin
      errors++;
      $error("FAIL busy_cycles observed=%0d expected=%0d", cnt, 8);
    end
    write = 1'b0; clr = 1'b0;
    sweep("after_clear");

    // Writes to address 0 on the ZERO_REG instance.
    write = 1'b1; addw = 3'd0; wd = 16'hFFFF; add1 = 3'd0; add2 = 3'd0;
    observe("zero_same");
    tick();
    write = 1'b0;
    observe("zero_next");

    // Reset in the middle of a clear.
    for (int i = 1; i < 8; i++) begin
      write = 1'b1; addw = 3'(i); wd = 16'h5A00 + 16'(i);
      tick();
    end
    write = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    add1 = 3'd6; add2 = 3'd1;
    observe("clear_cyc3");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sweep("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
